// File: rtl/mul_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_tracker
// Purpose  : 3-stage RV32M multiplier beside EX, with stage tags for hazard
//            detection and a dedicated writeback port.
//            Optional: MUL_PERF_CNT_EN enables the issued-multiply counter.
// Revision : 1.0 - initial release
// ============================================================================
module mul_pipe_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  E_RegMul,
    input  logic                  E_Flush,
    input  logic [REG_WIDTH-1:0]  E_Rd,
    input  logic [2:0]            E_Funct3,
    input  logic [DATA_WIDTH-1:0] E_A,
    input  logic [DATA_WIDTH-1:0] E_B,
    output logic                  P1_RegMul,
    output logic                  P2_RegMul,
    output logic                  P3_RegMul,
    output logic [REG_WIDTH-1:0]  P1_Rd,
    output logic [REG_WIDTH-1:0]  P2_Rd,
    output logic [REG_WIDTH-1:0]  P3_Rd,
    output logic                  WB_MulWrite,
    output logic [REG_WIDTH-1:0]  WB_MulRd,
    output logic [DATA_WIDTH-1:0] WB_MulData,
    output logic [31:0]           Mul_Count
);

    localparam int c_EW  = DATA_WIDTH + 1;      // extended operand width
    localparam int c_H   = DATA_WIDTH / 2;      // rs2 low-half width
    localparam int c_HW  = c_EW - c_H;          // rs2 signed high-half width
    localparam int c_PPW = c_EW + c_H;          // low partial product width
    localparam int c_HPW = 2*DATA_WIDTH - c_H;  // high partial product kept bits

    logic                  w_accept;
    logic                  w_a_signed;
    logic                  w_b_signed;

    logic                  p1_v_d, p1_v_q;
    logic [REG_WIDTH-1:0]  p1_rd_d, p1_rd_q;
    logic                  p1_sel_d, p1_sel_q;
    logic [c_EW-1:0]       p1_a_d, p1_a_q;
    logic [c_EW-1:0]       p1_b_d, p1_b_q;

    logic [c_PPW-1:0]      w_a_lo, w_b_lo;
    logic [c_HPW-1:0]      w_a_hi, w_b_hi;
    logic [c_PPW-1:0]      p2_lo_d, p2_lo_q;
    logic [c_HPW-1:0]      p2_hi_d, p2_hi_q;
    logic                  p2_v_q, p2_sel_q;
    logic [REG_WIDTH-1:0]  p2_rd_q;

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   p3_data_d, p3_data_q;
    logic                    p3_v_q;
    logic [REG_WIDTH-1:0]    p3_rd_q;

    assign w_accept   = E_RegMul & ~E_Flush & (E_Rd != '0) & ~E_Funct3[2];
    assign w_a_signed = (E_Funct3[1:0] == 2'b01) | (E_Funct3[1:0] == 2'b10);
    assign w_b_signed = (E_Funct3[1:0] == 2'b01);

    // Dropped issues load zeros so idle stages never toggle the datapath.
    always_comb begin
        p1_v_d   = w_accept;
        p1_rd_d  = '0;
        p1_sel_d = 1'b0;
        p1_a_d   = '0;
        p1_b_d   = '0;
        if (w_accept) begin
            p1_rd_d  = E_Rd;
            p1_sel_d = (E_Funct3[1:0] != 2'b00);
            p1_a_d   = {w_a_signed & E_A[DATA_WIDTH-1], E_A};
            p1_b_d   = {w_b_signed & E_B[DATA_WIDTH-1], E_B};
        end
    end

    // rs2 = b_hi * 2^H + b_lo, with b_lo unsigned and b_hi carrying the sign.
    always_comb begin
        w_a_lo  = {{(c_PPW-c_EW){p1_a_q[c_EW-1]}}, p1_a_q};
        w_b_lo  = {{(c_PPW-c_H){1'b0}}, p1_b_q[c_H-1:0]};
        w_a_hi  = {{(c_HPW-c_EW){p1_a_q[c_EW-1]}}, p1_a_q};
        w_b_hi  = {{(c_HPW-c_HW){p1_b_q[c_EW-1]}}, p1_b_q[c_EW-1:c_H]};
        p2_lo_d = w_a_lo * w_b_lo;
        p2_hi_d = w_a_hi * w_b_hi;
    end

    always_comb begin
        w_prod    = {{(2*DATA_WIDTH-c_PPW){p2_lo_q[c_PPW-1]}}, p2_lo_q}
                  + {p2_hi_q, {c_H{1'b0}}};
        p3_data_d = p2_sel_q ? w_prod[2*DATA_WIDTH-1:DATA_WIDTH]
                             : w_prod[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v_q    <= 1'b0;
            p1_rd_q   <= '0;
            p1_sel_q  <= 1'b0;
            p1_a_q    <= '0;
            p1_b_q    <= '0;
            p2_v_q    <= 1'b0;
            p2_rd_q   <= '0;
            p2_sel_q  <= 1'b0;
            p2_lo_q   <= '0;
            p2_hi_q   <= '0;
            p3_v_q    <= 1'b0;
            p3_rd_q   <= '0;
            p3_data_q <= '0;
        end else begin
            p1_v_q    <= p1_v_d;
            p1_rd_q   <= p1_rd_d;
            p1_sel_q  <= p1_sel_d;
            p1_a_q    <= p1_a_d;
            p1_b_q    <= p1_b_d;
            p2_v_q    <= p1_v_q;
            p2_rd_q   <= p1_rd_q;
            p2_sel_q  <= p1_sel_q;
            p2_lo_q   <= p2_lo_d;
            p2_hi_q   <= p2_hi_d;
            p3_v_q    <= p2_v_q;
            p3_rd_q   <= p2_rd_q;
            p3_data_q <= p3_data_d;
        end
    end

    assign P1_RegMul   = p1_v_q;
    assign P2_RegMul   = p2_v_q;
    assign P3_RegMul   = p3_v_q;
    assign P1_Rd       = p1_rd_q;
    assign P2_Rd       = p2_rd_q;
    assign P3_Rd       = p3_rd_q;
    assign WB_MulWrite = p3_v_q;
    assign WB_MulRd    = p3_rd_q;
    assign WB_MulData  = p3_data_q;

`ifdef MUL_PERF_CNT_EN
    logic [31:0] mul_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_count_q <= '0;
        end else if (w_accept) begin
            mul_count_q <= mul_count_q + 32'd1;
        end
    end

    assign Mul_Count = mul_count_q;
`else
    assign Mul_Count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_pipe_tracker
// Purpose  : Self-checking bench for mul_pipe_tracker against a 64-bit
//            arithmetic reference model with a 3-deep issue history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        E_RegMul = 1'b0;
    logic        E_Flush = 1'b0;
    logic [4:0]  E_Rd = '0;
    logic [2:0]  E_Funct3 = '0;
    logic [31:0] E_A = '0;
    logic [31:0] E_B = '0;
    logic        P1_RegMul, P2_RegMul, P3_RegMul;
    logic [4:0]  P1_Rd, P2_Rd, P3_Rd;
    logic        WB_MulWrite;
    logic [4:0]  WB_MulRd;
    logic [31:0] WB_MulData;
    logic [31:0] Mul_Count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] res;
    } rec_t;

    rec_t        hist[$];   // hist[0] = newest issue (P1) ... hist[2] = P3
    logic [31:0] exp_cnt = '0;

    mul_pipe_tracker #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_RegMul(E_RegMul), .E_Flush(E_Flush), .E_Rd(E_Rd),
        .E_Funct3(E_Funct3), .E_A(E_A), .E_B(E_B),
        .P1_RegMul(P1_RegMul), .P2_RegMul(P2_RegMul), .P3_RegMul(P3_RegMul),
        .P1_Rd(P1_Rd), .P2_Rd(P2_Rd), .P3_Rd(P3_Rd),
        .WB_MulWrite(WB_MulWrite), .WB_MulRd(WB_MulRd),
        .WB_MulData(WB_MulData), .Mul_Count(Mul_Count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          zb = longint'({32'b0, b});
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        case (f3[1:0])
            2'b01:   p = sa * sb;
            2'b10:   p = sa * zb;
            default: p = ua * ub;
        endcase
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit accepted(input logic v, input logic fl,
                                    input logic [4:0] rd, input logic [2:0] f3);
        return v && !fl && (rd != 5'd0) && (f3 < 3'd4);
    endfunction

    task automatic model_reset();
        rec_t r;
        r.v = 1'b0; r.rd = '0; r.res = '0;
        hist.delete();
        repeat (3) hist.push_back(r);
        exp_cnt = '0;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        E_RegMul = v; E_Flush = fl; E_Rd = rd; E_Funct3 = f3; E_A = a; E_B = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        rec_t r;
        r.v   = accepted(E_RegMul, E_Flush, E_Rd, E_Funct3);
        r.rd  = E_Rd;
        r.res = ref_mul(E_Funct3, E_A, E_B);
        @(posedge clk);
        #1;
        hist.push_front(r);
        void'(hist.pop_back());
`ifdef MUL_PERF_CNT_EN
        if (r.v) exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({P1_RegMul, P2_RegMul, P3_RegMul} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b want 000", {P1_RegMul, P2_RegMul, P3_RegMul}); end
        checks++; if ({P1_Rd, P2_Rd, P3_Rd} !== 15'd0) begin
            failures++; $display("FAIL reset_rd: got %h want 0", {P1_Rd, P2_Rd, P3_Rd}); end
        checks++; if ({WB_MulWrite, WB_MulRd, WB_MulData} !== 38'd0) begin
            failures++; $display("FAIL reset_wb: got %h want 0", {WB_MulWrite, WB_MulRd, WB_MulData}); end
        checks++; if (Mul_Count !== 32'd0) begin
            failures++; $display("FAIL reset_count: got %h want 0", Mul_Count); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 5'd5, 3'b000, 32'd7, 32'd6);
        step();
        idle();
        checks++; if (P1_RegMul !== 1'b1 || P1_Rd !== 5'd5) begin
            failures++; $display("FAIL basic_p1: got v=%b rd=%0d want v=1 rd=5", P1_RegMul, P1_Rd); end
        step();
        checks++; if (P2_RegMul !== 1'b1 || P2_Rd !== 5'd5 || P1_RegMul !== 1'b0) begin
            failures++; $display("FAIL basic_p2: got p2v=%b rd=%0d p1v=%b want 1 5 0", P2_RegMul, P2_Rd, P1_RegMul); end
        step();
        checks++; if (P3_RegMul !== 1'b1 || WB_MulWrite !== 1'b1 || WB_MulRd !== 5'd5) begin
            failures++; $display("FAIL basic_wb_tag: got v=%b we=%b rd=%0d want 1 1 5", P3_RegMul, WB_MulWrite, WB_MulRd); end
        checks++; if (WB_MulData !== 32'h0000002A) begin
            failures++; $display("FAIL basic_wb_data: got %h want 0000002a", WB_MulData); end
        step();
        checks++; if (WB_MulWrite !== 1'b0) begin
            failures++; $display("FAIL basic_one_cycle: got we=%b want 0", WB_MulWrite); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[3];
        want[0] = 32'h00000000; want[1] = 32'hFFFFFFFE; want[2] = 32'hFFFFFFFF;
        drive(1'b1, 1'b0, 5'd1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF); step();
        drive(1'b1, 1'b0, 5'd2, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF); step();
        drive(1'b1, 1'b0, 5'd3, 3'b010, 32'hFFFFFFFF, 32'd2);        step();
        idle();
        checks++; if ({P1_RegMul, P2_RegMul, P3_RegMul} !== 3'b111 ||
                      P1_Rd !== 5'd3 || P2_Rd !== 5'd2 || P3_Rd !== 5'd1) begin
            failures++; $display("FAIL b2b_tags: got v=%b rd=%0d/%0d/%0d want 111 3/2/1",
                {P1_RegMul, P2_RegMul, P3_RegMul}, P1_Rd, P2_Rd, P3_Rd); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (WB_MulWrite !== 1'b1 || WB_MulRd !== 5'(i + 1) || WB_MulData !== want[i]) begin
                failures++; $display("FAIL b2b_wb%0d: got we=%b rd=%0d data=%h want 1 %0d %h",
                    i, WB_MulWrite, WB_MulRd, WB_MulData, i + 1, want[i]); end
            step();
        end
    endtask

    task automatic test_drops();
        logic [31:0] cnt_before;
        cnt_before = exp_cnt;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(1'b1, 1'b0, 5'd0, 3'b000, 32'd3, 32'd4);
                1: drive(1'b1, 1'b1, 5'd9, 3'b000, 32'd3, 32'd4);
                2: drive(1'b1, 1'b0, 5'd9, 3'b100, 32'd3, 32'd4);
                3: drive(1'b1, 1'b0, 5'd9, 3'b111, 32'd3, 32'd4);
                default: idle();
            endcase
            step();
            checks++; if ({P1_RegMul, P2_RegMul, P3_RegMul, WB_MulWrite} !== 4'b0000) begin
                failures++; $display("FAIL drop_flags%0d: got %b want 0000", i,
                    {P1_RegMul, P2_RegMul, P3_RegMul, WB_MulWrite}); end
        end
        checks++; if (Mul_Count !== cnt_before) begin
            failures++; $display("FAIL drop_count: got %h want %h", Mul_Count, cnt_before); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 5'd10, 3'b000, 32'd11, 32'd12); step();
        drive(1'b1, 1'b0, 5'd11, 3'b011, 32'd13, 32'd14); step();
        idle();
        checks++; if ({P1_RegMul, P2_RegMul} !== 2'b11) begin
            failures++; $display("FAIL areset_pre: got %b want 11", {P1_RegMul, P2_RegMul}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({P1_RegMul, P2_RegMul, P3_RegMul, WB_MulWrite} !== 4'b0000) begin
            failures++; $display("FAIL areset_async: got %b want 0000",
                {P1_RegMul, P2_RegMul, P3_RegMul, WB_MulWrite}); end
        checks++; if (Mul_Count !== 32'd0 || WB_MulData !== 32'd0) begin
            failures++; $display("FAIL areset_clear: got cnt=%h data=%h want 0 0", Mul_Count, WB_MulData); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (WB_MulWrite !== 1'b0) begin
                failures++; $display("FAIL areset_no_wb%0d: got we=%b want 0", i, WB_MulWrite); end
        end
        drive(1'b1, 1'b0, 5'd7, 3'b000, 32'd3, 32'd3); step();
        idle(); step(); step();
        checks++; if (WB_MulWrite !== 1'b1 || WB_MulRd !== 5'd7 || WB_MulData !== 32'd9) begin
            failures++; $display("FAIL areset_after: got we=%b rd=%0d data=%h want 1 7 00000009",
                WB_MulWrite, WB_MulRd, WB_MulData); end
        step();
    endtask

    task automatic test_extremes();
        logic [31:0] want[3];
        want[0] = 32'h80000000; want[1] = 32'h00000000; want[2] = 32'h40000000;
        drive(1'b1, 1'b0, 5'd4, 3'b000, 32'h80000000, 32'hFFFFFFFF); step();
        drive(1'b1, 1'b0, 5'd5, 3'b001, 32'h80000000, 32'hFFFFFFFF); step();
        drive(1'b1, 1'b0, 5'd6, 3'b011, 32'h80000000, 32'h80000000); step();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (WB_MulWrite !== 1'b1 || WB_MulRd !== 5'(i + 4) || WB_MulData !== want[i]) begin
                failures++; $display("FAIL extreme%0d: got we=%b rd=%0d data=%h want 1 %0d %h",
                    i, WB_MulWrite, WB_MulRd, WB_MulData, i + 4, want[i]); end
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] corner[6];
        logic [31:0] a, b;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF; corner[5] = 32'h0000FFFF;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 4) == 0 ? $urandom_range(4, 7)
                                                                          : $urandom_range(0, 3)),
                  a, b);
            step();
            checks++; if ({P1_RegMul, P2_RegMul, P3_RegMul} !== {hist[0].v, hist[1].v, hist[2].v}) begin
                failures++; $display("FAIL rand_flags@%0d: got %b want %b", i,
                    {P1_RegMul, P2_RegMul, P3_RegMul}, {hist[0].v, hist[1].v, hist[2].v}); end
            if (hist[0].v) begin
                checks++; if (P1_Rd !== hist[0].rd) begin
                    failures++; $display("FAIL rand_p1rd@%0d: got %0d want %0d", i, P1_Rd, hist[0].rd); end
            end
            if (hist[1].v) begin
                checks++; if (P2_Rd !== hist[1].rd) begin
                    failures++; $display("FAIL rand_p2rd@%0d: got %0d want %0d", i, P2_Rd, hist[1].rd); end
            end
            checks++; if (WB_MulWrite !== hist[2].v) begin
                failures++; $display("FAIL rand_we@%0d: got %b want %b", i, WB_MulWrite, hist[2].v); end
            if (hist[2].v) begin
                checks++; if (WB_MulRd !== hist[2].rd || WB_MulData !== hist[2].res) begin
                    failures++; $display("FAIL rand_wb@%0d: got rd=%0d data=%h want rd=%0d data=%h",
                        i, WB_MulRd, WB_MulData, hist[2].rd, hist[2].res); end
            end
            checks++; if (Mul_Count !== exp_cnt) begin
                failures++; $display("FAIL rand_count@%0d: got %h want %h", i, Mul_Count, exp_cnt); end
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_counter();
`ifdef MUL_PERF_CNT_EN
        force dut.mul_count_q = 32'hFFFFFFFE;
        #1;
        release dut.mul_count_q;
        exp_cnt = 32'hFFFFFFFE;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'(i + 20), 3'b000, 32'd2, 32'd2);
            step();
        end
        idle();
        step();
        checks++; if (Mul_Count !== exp_cnt) begin
            failures++; $display("FAIL counter: got %h want %h", Mul_Count, exp_cnt); end
`ifdef MUL_PERF_CNT_EN
        checks++; if (Mul_Count !== 32'h00000001) begin
            failures++; $display("FAIL counter_wrap: got %h want 00000001", Mul_Count); end
`else
        checks++; if (Mul_Count !== 32'h00000000) begin
            failures++; $display("FAIL counter_off: got %h want 00000000", Mul_Count); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_drops();
        test_async_reset();
        test_extremes();
        test_random();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_pipe_tracker.md
Name: mul_pipe_tracker

Overview:
- 3-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) that sits beside the EX stage.
- Produces the in-flight tag vector P1/P2/P3 (RegMul flag + Rd) that the hazard detection unit consumes.
- Drives the dedicated multiplier writeback port into the register file.
- Never stalls: ID-side hazard logic guarantees no issue conflicts and no writeback collisions, so this block advances every cycle.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- REG_WIDTH, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E_RegMul  input  1  EX-stage instruction is a multiply (issue request).
- E_Flush  input  1  squash the EX-stage instruction this cycle.
- E_Rd  input  REG_WIDTH  destination of EX-stage instruction.
- E_Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx illegal.
- E_A  input  DATA_WIDTH  rs1 operand, already forwarded.
- E_B  input  DATA_WIDTH  rs2 operand, already forwarded.
- P1_RegMul, P2_RegMul, P3_RegMul  output  1 each  stage valid flags.
- P1_Rd, P2_Rd, P3_Rd  output  REG_WIDTH each  stage destination tags.
- WB_MulWrite  output  1  multiplier writeback enable (equals P3_RegMul).
- WB_MulRd  output  REG_WIDTH  writeback register (equals P3_Rd).
- WB_MulData  output  DATA_WIDTH  writeback result.
- Mul_Count  output  32  issued-multiply counter (see Optional Feature).

Behaviour:

Issue:
- accept = E_RegMul & ~E_Flush & (E_Rd != 0) & ~E_Funct3[2].
- rd=0 and illegal funct3 are silently dropped: nothing enters P1 and no flag is raised.

Stage advance:
- On every rising clk, P1<-issue, P2<-P1, P3<-P2.
- Each stage holds valid, rd, funct3 and intermediate product state.
- No enable and no backpressure.

Latency:
- Issue at edge t: P1 valid after t, P2 after t+1, P3 after t+2.
- Writeback (WB_Mul*) is valid during the cycle following edge t+2, i.e. 3 cycles after issue.
- Throughput: one multiply per cycle.

Arithmetic:
- Extend operands to 33 bits. rs1 signed for 001/010, unsigned for 011/000. rs2 signed for 001 only.
- Form the 66-bit signed product.
- 000 returns product[31:0]; 001/010/011 return product[63:32].
- Result must be bit-exact to the RV32M spec.
- How the partial-product/accumulation work is split across P1..P3 is implementation choice, but all state is registered and WB_MulData must come from P3 registers, with no combinational path from E_* inputs.

Tag outputs:
- Driven directly from stage registers (glitch-free, combinationally usable by the hazard unit).
- Invalid stages drive RegMul=0. Rd of an invalid stage is don't-care but must not be X after reset.

Reset:
- Asynchronous, rst_n low clears every stage valid flag, rd and data to 0.
- All outputs therefore read 0 during reset, including Mul_Count.
- Reset mid-operation discards all in-flight multiplies; no writeback is issued for them.
- The first issue after rst_n deassertion behaves normally.

Simultaneous events:
- E_Flush with E_RegMul drops the issue.
- Flush never affects P1..P3, since those instructions are already past EX and committed.
- Same rd in consecutive stages is legal and retires in order.

Optional Feature:
- Macro MUL_PERF_CNT_EN.
- Defined: Mul_Count is a 32-bit register, incremented by 1 on each accepted issue, wrapping 0xFFFFFFFF->0, cleared by reset.
- Undefined: the counter logic is absent and Mul_Count is tied to 0. The port always exists.

Test Plan:
- Issue MUL rd=5, A=7, B=6 at edge t -> P1_Rd=5 after t, P3_RegMul=1 after t+2, WB_MulData=0x0000002A, WB_MulRd=5 for exactly one cycle.
- Back-to-back: MULH(-1,-1) rd=1, MULHU(0xFFFFFFFF,0xFFFFFFFF) rd=2, MULHSU(0xFFFFFFFF,2) rd=3 on three consecutive cycles ->
  - P1/P2/P3 tags 3/2/1 simultaneously on the third cycle;
  - results 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF in order on consecutive writeback cycles.
- Drops: issue with rd=0, issue with E_Flush=1, and issue with funct3=100 -> no P*_RegMul ever asserted, WB_MulWrite stays 0, Mul_Count unchanged (macro on).
- Reset: assert rst_n=0 while P1 and P2 are valid -> all flags 0 immediately (asynchronous, not waiting for clk), no writeback. Issue MUL(3,3) after release -> 9 after 3 cycles.
- Signed extremes: MUL(0x80000000,0xFFFFFFFF) -> 0x80000000. MULH same operands -> 0x00000000. MULHU(0x80000000,0x80000000) -> 0x40000000.
- Counter: with MUL_PERF_CNT_EN, preload to 0xFFFFFFFE by issuing/forcing, then 3 accepted issues -> 0x00000001. Without the macro -> Mul_Count constant 0.
